// File: rtl/axi_wr_slave_pkg.sv
// rtl/axi_wr_slave_pkg.sv - shared encodings for the AXI write slave
// Purpose: AXI burst/response encodings and the write FSM state type,
//          shared by the slave top and its testbench.
// Ports:   none (package).
package axi_wr_slave_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } wr_state_e;

endpackage

// File: rtl/axi_slave_sdpram.sv
// rtl/axi_slave_sdpram.sv - simple dual-port RAM, byte-enabled write, registered read
// Purpose: storage behind the AXI write slave. One write port with per-byte
//          enables, one read port with a single registered (read-first) stage.
// Ports:   clk_i   - clock (rising edge)
//          rst_ni  - asynchronous active-low reset (clears the read register only)
//          we_i, waddr_i, wdata_i, wstrb_i - write port
//          raddr_i, rdata_o                - read port, 1-cycle latency
module axi_slave_sdpram #(
  parameter int AW = 12,
  parameter int DW = 256
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW/8-1:0] wstrb_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [DW-1:0]   rdata_o
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  // The array has no reset so that a reset never disturbs stored contents.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < DW/8; b++) begin
        if (wstrb_i[b]) begin
          mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // Non-blocking read alongside the write gives old data on a same-word collision.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_wr_slave.sv
// rtl/axi_wr_slave.sv - AXI write-channel slave storing bursts into on-chip RAM
// Purpose: accepts AW/W bursts (FIXED, INCR; reserved types treated as INCR
//          and flagged SLVERR), writes beats into a byte-enabled RAM, and
//          returns one B response per burst. A backdoor port reads the RAM.
// Ports:   axi_aclk/axi_resetn - clock, asynchronous active-low reset
//          axi_aw*             - write address channel (1-entry holding register)
//          axi_w*              - write data channel
//          axi_b*              - write response channel
//          dbg_addr/dbg_rdata  - backdoor RAM read, 1-cycle latency
module axi_wr_slave
  import axi_wr_slave_pkg::*;
#(
  parameter int IDSIZE = 4,
  parameter int ASIZE  = 29,
  parameter int LSIZE  = 9,
  parameter int DSIZE  = 256,
  parameter int RAM_AW = 12
) (
  input  logic               axi_aclk,
  input  logic               axi_resetn,
  input  logic [IDSIZE-1:0]  axi_awid,
  input  logic [ASIZE-1:0]   axi_awaddr,
  input  logic [LSIZE-1:0]   axi_awlen,
  input  logic [1:0]         axi_awburst,
  input  logic               axi_awvalid,
  output logic               axi_awready,
  input  logic [DSIZE-1:0]   axi_wdata,
  input  logic [DSIZE/8-1:0] axi_wstrb,
  input  logic               axi_wlast,
  input  logic               axi_wvalid,
  output logic               axi_wready,
  output logic [IDSIZE-1:0]  axi_bid,
  output logic [1:0]         axi_bresp,
  output logic               axi_bvalid,
  input  logic               axi_bready,
  input  logic [RAM_AW-1:0]  dbg_addr,
  output logic [DSIZE-1:0]   dbg_rdata
);

  localparam int BSH = $clog2(DSIZE/8);

  // AW holding register
  logic              aw_full_q, aw_full_d;
  logic              awready_q, awready_d;
  logic [IDSIZE-1:0] aw_id_q, aw_id_d;
  logic [RAM_AW-1:0] aw_idx_q, aw_idx_d;
  logic [LSIZE-1:0]  aw_len_q, aw_len_d;
  logic [1:0]        aw_burst_q, aw_burst_d;

  // Burst being executed
  wr_state_e         state_q, state_d;
  logic [IDSIZE-1:0] bid_q, bid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [RAM_AW-1:0] idx_q, idx_d;
  logic [LSIZE-1:0]  cnt_q, cnt_d;
  logic              fixed_q, fixed_d;

  logic aw_push, aw_pop, beat, last_beat;

  always_comb begin
    state_d    = state_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    fixed_d    = fixed_q;
    aw_id_d    = aw_id_q;
    aw_idx_d   = aw_idx_q;
    aw_len_d   = aw_len_q;
    aw_burst_d = aw_burst_q;
    aw_pop     = 1'b0;
    beat       = 1'b0;
    last_beat  = 1'b0;
    aw_push    = axi_awvalid && awready_q;

    if (aw_push) begin
      aw_id_d    = axi_awid;
      aw_idx_d   = axi_awaddr[RAM_AW+BSH-1:BSH];
      aw_len_d   = axi_awlen;
      aw_burst_d = axi_awburst;
    end

    case (state_q)
      ST_IDLE: begin
        if (aw_full_q) begin
          aw_pop  = 1'b1;
          bid_d   = aw_id_q;
          idx_d   = aw_idx_q;
          cnt_d   = aw_len_q;
          fixed_d = (aw_burst_q == BURST_FIXED);
          // Reserved burst types still run as INCR but are reported as errors.
          bresp_d = (aw_burst_q == BURST_FIXED || aw_burst_q == BURST_INCR) ? RESP_OKAY : RESP_SLVERR;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (axi_wvalid) begin
          beat      = 1'b1;
          last_beat = (cnt_q == '0);
          // The beat counter, not wlast, ends the burst; a misplaced wlast only flags SLVERR.
          if (axi_wlast != last_beat) begin
            bresp_d = RESP_SLVERR;
          end
          if (!fixed_q) begin
            idx_d = idx_q + RAM_AW'(1);
          end
          cnt_d = cnt_q - LSIZE'(1);
          if (last_beat) begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (axi_bready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    aw_full_d = (aw_full_q && !aw_pop) || aw_push;
    awready_d = !aw_full_d;
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q    <= ST_IDLE;
      aw_full_q  <= 1'b0;
      awready_q  <= 1'b0;
      aw_id_q    <= '0;
      aw_idx_q   <= '0;
      aw_len_q   <= '0;
      aw_burst_q <= '0;
      bid_q      <= '0;
      bresp_q    <= RESP_OKAY;
      idx_q      <= '0;
      cnt_q      <= '0;
      fixed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      aw_full_q  <= aw_full_d;
      awready_q  <= awready_d;
      aw_id_q    <= aw_id_d;
      aw_idx_q   <= aw_idx_d;
      aw_len_q   <= aw_len_d;
      aw_burst_q <= aw_burst_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      fixed_q    <= fixed_d;
    end
  end

  assign axi_awready = awready_q;
  assign axi_wready  = (state_q == ST_DATA);
  assign axi_bvalid  = (state_q == ST_RESP);
  assign axi_bid     = bid_q;
  assign axi_bresp   = bresp_q;

  axi_slave_sdpram #(
    .AW(RAM_AW),
    .DW(DSIZE)
  ) u_ram (
    .clk_i  (axi_aclk),
    .rst_ni (axi_resetn),
    .we_i   (beat),
    .waddr_i(idx_q),
    .wdata_i(axi_wdata),
    .wstrb_i(axi_wstrb),
    .raddr_i(dbg_addr),
    .rdata_o(dbg_rdata)
  );

endmodule

// File: tb/tb_axi_wr_slave.sv
// tb/tb_axi_wr_slave.sv - self-checking bench for axi_wr_slave
module tb_axi_wr_slave;

  typedef struct {
    logic [3:0]  id;
    logic [28:0] addr;
    logic [8:0]  len;
    logic [1:0]  burst;
  } aw_t;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  strb;
    logic         last;
    int           idx;
    bit           fin;
    bit           first;
  } w_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } b_t;

  logic         axi_aclk = 1'b0;
  logic         axi_resetn;
  logic [3:0]   axi_awid;
  logic [28:0]  axi_awaddr;
  logic [8:0]   axi_awlen;
  logic [1:0]   axi_awburst;
  logic         axi_awvalid;
  logic         axi_awready;
  logic [255:0] axi_wdata;
  logic [31:0]  axi_wstrb;
  logic         axi_wlast;
  logic         axi_wvalid;
  logic         axi_wready;
  logic [3:0]   axi_bid;
  logic [1:0]   axi_bresp;
  logic         axi_bvalid;
  logic         axi_bready;
  logic [11:0]  dbg_addr;
  logic [255:0] dbg_rdata;

  always #5 axi_aclk = ~axi_aclk;

  axi_wr_slave dut (
    .axi_aclk   (axi_aclk),
    .axi_resetn (axi_resetn),
    .axi_awid   (axi_awid),
    .axi_awaddr (axi_awaddr),
    .axi_awlen  (axi_awlen),
    .axi_awburst(axi_awburst),
    .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_wdata  (axi_wdata),
    .axi_wstrb  (axi_wstrb),
    .axi_wlast  (axi_wlast),
    .axi_wvalid (axi_wvalid),
    .axi_wready (axi_wready),
    .axi_bid    (axi_bid),
    .axi_bresp  (axi_bresp),
    .axi_bvalid (axi_bvalid),
    .axi_bready (axi_bready),
    .dbg_addr   (dbg_addr),
    .dbg_rdata  (dbg_rdata)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_b_cyc = -1;
  int gap_last = -1;
  int bready_low = 0;
  int held = 0;
  aw_t aw_q[$];
  w_t  w_q[$];
  b_t  exp_b[$];
  logic [255:0] ref_mem [4096];
  bit ref_known [4096];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive();
    if (aw_q.size() > 0) begin
      axi_awvalid = 1'b1;
      axi_awid    = aw_q[0].id;
      axi_awaddr  = aw_q[0].addr;
      axi_awlen   = aw_q[0].len;
      axi_awburst = aw_q[0].burst;
    end else begin
      axi_awvalid = 1'b0;
    end
    if (w_q.size() > 0) begin
      axi_wvalid = 1'b1;
      axi_wdata  = w_q[0].data;
      axi_wstrb  = w_q[0].strb;
      axi_wlast  = w_q[0].last;
    end else begin
      axi_wvalid = 1'b0;
      axi_wlast  = 1'b0;
    end
    axi_bready = (bready_low == 0);
  endtask

  // Queue one burst: AW, its beats with their target words, and the expected response.
  task automatic burst(input logic [3:0] id, input int addr, input int len, input logic [1:0] bt,
                       input int wl_at, input logic [31:0] strb, input bit rnd_strb,
                       input logic [255:0] dpat, input bit rnd_data);
    aw_t a;
    w_t  w;
    b_t  b;
    bit  err;
    int  base;
    base    = addr / 32;
    a.id    = id;
    a.addr  = 29'(addr);
    a.len   = 9'(len);
    a.burst = bt;
    aw_q.push_back(a);
    err = (bt == 2'b10 || bt == 2'b11);
    for (int i = 0; i <= len; i++) begin
      w.data  = rnd_data ? rand256() : dpat;
      w.strb  = rnd_strb ? $urandom : strb;
      w.last  = (i == wl_at);
      w.fin   = (i == len);
      w.first = (i == 0);
      w.idx   = (bt == 2'b00) ? (base % 4096) : ((base + i) % 4096);
      if (w.last != w.fin) err = 1'b1;
      w_q.push_back(w);
    end
    b.id   = id;
    b.resp = err ? 2'b10 : 2'b00;
    exp_b.push_back(b);
    drive();
  endtask

  // One clock: decide handshakes before the edge, update the model after it.
  task automatic tick();
    bit aw_hs, w_hs, b_hs, pbv, pbr;
    logic [3:0] pbid;
    logic [1:0] pbresp;
    w_t bt;
    b_t eb;
    aw_hs  = axi_awvalid && axi_awready;
    w_hs   = axi_wvalid && axi_wready;
    b_hs   = axi_bvalid && axi_bready;
    pbv    = axi_bvalid;
    pbr    = axi_bready;
    pbid   = axi_bid;
    pbresp = axi_bresp;
    if (axi_bvalid && !axi_bready && bready_low > 0) begin
      bready_low--;
      held++;
    end
    if (b_hs) begin
      if (exp_b.size() == 0) begin
        chk("b_unexpected", axi_bvalid, 0);
      end else begin
        eb = exp_b.pop_front();
        chk("bid", axi_bid, eb.id);
        chk("bresp", axi_bresp, eb.resp);
      end
      last_b_cyc = cyc;
    end
    if (w_hs && w_q.size() > 0 && w_q[0].first && last_b_cyc >= 0) gap_last = cyc - last_b_cyc;
    @(negedge axi_aclk);
    cyc++;
    if (aw_hs && aw_q.size() > 0) aw_q.delete(0);
    if (w_hs && w_q.size() > 0) begin
      bt = w_q.pop_front();
      if (ref_known[bt.idx] && dbg_addr == 12'(bt.idx)) chk("read_first", dbg_rdata, ref_mem[bt.idx]);
      for (int b = 0; b < 32; b++) begin
        if (bt.strb[b]) ref_mem[bt.idx][b*8 +: 8] = bt.data[b*8 +: 8];
      end
      ref_known[bt.idx] = ref_known[bt.idx] || (bt.strb == 32'hFFFF_FFFF);
      if (bt.fin) chk("bvalid_after_last", axi_bvalid, 1);
      else        chk("bvalid_mid_burst", axi_bvalid, 0);
    end
    if (pbv && !pbr) begin
      chk("bvalid_hold", axi_bvalid, 1);
      chk("bid_hold", axi_bid, pbid);
      chk("bresp_hold", axi_bresp, pbresp);
    end
    if (axi_bvalid) chk("wready_in_resp", axi_wready, 0);
    drive();
  endtask

  task automatic run_idle(input int limit);
    int n;
    n = 0;
    while ((aw_q.size() + w_q.size() + exp_b.size()) > 0 && n < limit) begin
      tick();
      n++;
    end
    chk("run_done", aw_q.size() + w_q.size() + exp_b.size(), 0);
  endtask

  task automatic check_mem(input int w);
    dbg_addr = 12'(w);
    @(negedge axi_aclk);
    chk($sformatf("mem_%0d", w), dbg_rdata, ref_mem[w]);
  endtask

  task automatic do_reset();
    axi_resetn = 1'b0;
    aw_q.delete();
    w_q.delete();
    exp_b.delete();
    bready_low = 0;
    drive();
    #1;
    chk("rst_awready", axi_awready, 0);
    chk("rst_wready", axi_wready, 0);
    chk("rst_bvalid", axi_bvalid, 0);
    chk("rst_bid", axi_bid, 0);
    chk("rst_bresp", axi_bresp, 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);
    repeat (2) @(negedge axi_aclk);
    axi_resetn = 1'b1;
    chk("awready_before_edge", axi_awready, 0);
    @(negedge axi_aclk);
    chk("awready_after_release", axi_awready, 1);
    last_b_cyc = -1;
  endtask

  initial begin
    axi_resetn  = 1'b1;
    axi_awid    = '0;
    axi_awaddr  = '0;
    axi_awlen   = '0;
    axi_awburst = '0;
    axi_awvalid = 1'b0;
    axi_wdata   = '0;
    axi_wstrb   = '0;
    axi_wlast   = 1'b0;
    axi_wvalid  = 1'b0;
    axi_bready  = 1'b1;
    dbg_addr    = '0;
    @(negedge axi_aclk);
    do_reset();

    // single beat at 0x40 -> word 2
    burst(4'd5, 'h40, 0, 2'b01, 0, 32'hFFFF_FFFF, 0, {32{8'hA5}}, 0);
    run_idle(50);
    check_mem(2);

    // two back-to-back 256-beat INCR bursts, second AW offered mid-burst
    burst(4'd1, 'h0, 255, 2'b01, 255, 32'hFFFF_FFFF, 0, '0, 1);
    repeat (20) tick();
    burst(4'd2, 'h2000, 255, 2'b01, 255, 32'hFFFF_FFFF, 0, '0, 1);
    chk("aw_mid_burst_ready", axi_awready, 1);
    run_idle(1200);
    chk("burst_gap", gap_last, 2);
    for (int w = 0; w < 512; w++) check_mem(w);

    // partial strobe over a preloaded word (also exercises read-first)
    burst(4'd3, 384 * 32, 0, 2'b01, 0, 32'hFFFF_FFFF, 0, '0, 1);
    run_idle(50);
    check_mem(384);
    burst(4'd3, 384 * 32, 0, 2'b01, 0, 32'h0000_000F, 0, '0, 1);
    run_idle(50);
    check_mem(384);

    // error responses and FIXED
    burst(4'd6, 1024 * 32, 3, 2'b01, 1, 32'hFFFF_FFFF, 0, '0, 1);
    burst(4'd7, 1152 * 32, 0, 2'b10, 0, 32'hFFFF_FFFF, 0, '0, 1);
    burst(4'd8, 1300 * 32, 2, 2'b11, 2, 32'hFFFF_FFFF, 0, '0, 1);
    burst(4'd9, 1400 * 32, 1, 2'b01, -1, 32'hFFFF_FFFF, 0, '0, 1);
    burst(4'd4, 1200 * 32, 3, 2'b00, 3, 32'hFFFF_FFFF, 0, '0, 1);
    run_idle(200);
    for (int w = 1024; w < 1028; w++) check_mem(w);
    check_mem(1152);
    for (int w = 1300; w < 1303; w++) check_mem(w);
    check_mem(1400);
    check_mem(1401);
    check_mem(1200);

    // bready held low for 10 cycles with a second AW buffered
    held = 0;
    bready_low = 10;
    burst(4'd10, 'hA000, 2, 2'b01, 2, 32'hFFFF_FFFF, 0, '0, 1);
    burst(4'd11, 'hB000, 1, 2'b01, 1, 32'hFFFF_FFFF, 0, '0, 1);
    begin
      int n;
      n = 0;
      while ((aw_q.size() + w_q.size() + exp_b.size()) > 0 && n < 200) begin
        tick();
        n++;
        if (axi_bvalid && !axi_bready) chk("aw_buffered_awready", axi_awready, 0);
      end
    end
    chk("run_done_hold", aw_q.size() + w_q.size() + exp_b.size(), 0);
    chk("bready_hold_cycles", held, 10);

    // INCR wrapping from the last word
    burst(4'd12, 4095 * 32, 1, 2'b01, 1, 32'hFFFF_FFFF, 0, '0, 1);
    run_idle(50);
    check_mem(4095);
    check_mem(0);

    // reset in the middle of a burst
    burst(4'd13, 700 * 32, 7, 2'b01, 7, 32'hFFFF_FFFF, 0, '0, 1);
    run_idle(100);
    dbg_addr = 12'd701;
    burst(4'd14, 700 * 32, 7, 2'b01, 7, 32'h0, 1, '0, 1);
    repeat (5) tick();
    do_reset();
    repeat (5) begin
      tick();
      chk("no_bvalid_after_reset", axi_bvalid, 0);
    end
    burst(4'd15, 640 * 32, 3, 2'b01, 3, 32'hFFFF_FFFF, 0, '0, 1);
    run_idle(50);
    for (int w = 700; w < 708; w++) check_mem(w);
    for (int w = 640; w < 644; w++) check_mem(w);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
